// File: rtl/imm_pkg.sv
// Shared decode constants for the pipelined immediate generator.
package imm_pkg;

  // Base opcodes (instr[6:0]) that carry an immediate
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_FENCE  = 7'b0001111;
  localparam logic [6:0] OP_SYSTEM = 7'b1110011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;

  // Immediate format class reported alongside the value
  typedef enum logic [2:0] {
    IMM_NONE = 3'd0,
    IMM_I    = 3'd1,
    IMM_S    = 3'd2,
    IMM_B    = 3'd3,
    IMM_U    = 3'd4,
    IMM_J    = 3'd5,
    IMM_Z    = 3'd6
  } imm_type_e;

endpackage

// File: rtl/imm_gen_pipe_if.sv
// Fetch-side and register-read-side handshakes of the immediate generator.
interface imm_gen_pipe_if
  import imm_pkg::*;
#(
  parameter int XLEN  = 32,
  parameter int TAG_W = 32
);
  logic             in_valid;
  logic             in_ready;
  logic [31:0]      in_instr;
  logic [TAG_W-1:0] in_tag;

  logic             out_valid;
  logic             out_ready;
  logic [XLEN-1:0]  out_imm;
  imm_type_e        out_type;
  logic             out_illegal;
  logic [TAG_W-1:0] out_tag;

  // Block side: consumes instructions, produces immediates
  modport slave (
    input  in_valid, in_instr, in_tag, out_ready,
    output in_ready, out_valid, out_imm, out_type, out_illegal, out_tag
  );

  // Environment side: fetch upstream plus register-read downstream
  modport master (
    output in_valid, in_instr, in_tag, out_ready,
    input  in_ready, out_valid, out_imm, out_type, out_illegal, out_tag
  );
endinterface

// File: rtl/imm_decode.sv
// Combinational RV immediate decode: value, format class and illegal flag.
module imm_decode
  import imm_pkg::*;
#(
  parameter int XLEN    = 32,
  parameter bit EN_ZIMM = 1'b1
) (
  input  logic [31:0]     instr,
  output logic [XLEN-1:0] imm,
  output imm_type_e       typ,
  output logic            illegal
);

  // Select the immediate layout from the opcode; unknown encodings read as NONE
  always_comb begin
    imm     = '0;
    typ     = IMM_NONE;
    illegal = 1'b0;
    if (instr[1:0] != 2'b11) begin
      illegal = 1'b1;
    end else begin
      case (instr[6:0])
        OP_LOAD, OP_IMM, OP_JALR, OP_FENCE: begin
          imm = XLEN'($signed(instr[31:20]));
          typ = IMM_I;
        end
        OP_SYSTEM: begin
          // CSR*I forms carry a 5-bit unsigned operand in the rs1 slot
          if (EN_ZIMM && instr[14]) begin
            imm = XLEN'(instr[19:15]);
            typ = IMM_Z;
          end else begin
            imm = XLEN'($signed(instr[31:20]));
            typ = IMM_I;
          end
        end
        OP_STORE: begin
          imm = XLEN'($signed({instr[31:25], instr[11:7]}));
          typ = IMM_S;
        end
        OP_BRANCH: begin
          imm = XLEN'($signed({instr[31], instr[7], instr[30:25], instr[11:8], 1'b0}));
          typ = IMM_B;
        end
        OP_LUI, OP_AUIPC: begin
          imm = XLEN'($signed({instr[31:12], 12'h000}));
          typ = IMM_U;
        end
        OP_JAL: begin
          imm = XLEN'($signed({instr[31], instr[19:12], instr[20], instr[30:21], 1'b0}));
          typ = IMM_J;
        end
        default: illegal = 1'b1;
      endcase
    end
  end

endmodule

// File: rtl/imm_gen_pipe.sv
// Registered immediate generator: decode, one output stage and a one-entry skid.
module imm_gen_pipe
  import imm_pkg::*;
#(
  parameter int XLEN    = 32,
  parameter int TAG_W   = 32,
  parameter bit EN_ZIMM = 1'b1
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           flush,
  imm_gen_pipe_if.slave  bus
);

  typedef struct packed {
    logic [XLEN-1:0]  imm;
    imm_type_e        typ;
    logic             illegal;
    logic [TAG_W-1:0] tag;
  } entry_t;

  logic [XLEN-1:0] dec_imm;
  imm_type_e       dec_typ;
  logic            dec_ill;
  entry_t          dec_e;
  entry_t          out_q;
  entry_t          skid_q;
  logic            out_vld;
  logic            skid_vld;
  logic            accept;

  imm_decode #(
    .XLEN    (XLEN),
    .EN_ZIMM (EN_ZIMM)
  ) u_dec (
    .instr   (bus.in_instr),
    .imm     (dec_imm),
    .typ     (dec_typ),
    .illegal (dec_ill)
  );

  assign dec_e  = '{imm: dec_imm, typ: dec_typ, illegal: dec_ill, tag: bus.in_tag};
  // Ready only depends on skid occupancy, so no combinational path from out_ready
  assign accept = bus.in_valid & ~skid_vld;

  // Output stage + skid: skid drains first, otherwise new items go to the
  // output when it frees up this cycle, else park in the skid
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      out_vld  <= 1'b0;
      skid_vld <= 1'b0;
      out_q    <= '0;
      skid_q   <= '0;
    end else if (flush) begin
      out_vld  <= 1'b0;
      skid_vld <= 1'b0;
    end else if (skid_vld) begin
      // in_ready is low here, so no new item can arrive alongside a drain
      if (bus.out_ready) begin
        out_q    <= skid_q;
        skid_vld <= 1'b0;
      end
    end else if (accept) begin
      if (!out_vld || bus.out_ready) begin
        out_q   <= dec_e;
        out_vld <= 1'b1;
      end else begin
        skid_q   <= dec_e;
        skid_vld <= 1'b1;
      end
    end else if (bus.out_ready) begin
      out_vld <= 1'b0;
    end
  end

  assign bus.in_ready    = ~skid_vld;
  assign bus.out_valid   = out_vld;
  assign bus.out_imm     = out_q.imm;
  assign bus.out_type    = out_q.typ;
  assign bus.out_illegal = out_q.illegal;
  assign bus.out_tag     = out_q.tag;

endmodule

// File: tb/tb_imm_gen_pipe.sv
// Bench for imm_gen_pipe: vector table, handshake corner sequences, random stream.
module tb_imm_gen_pipe;
  import imm_pkg::*;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic flush = 1'b0;
  int   tests = 0;
  int   fails = 0;

  always #5 clk = ~clk;

  imm_gen_pipe_if #(.XLEN(32), .TAG_W(32)) b32 ();
  imm_gen_pipe_if #(.XLEN(64), .TAG_W(32)) b64 ();
  imm_gen_pipe_if #(.XLEN(32), .TAG_W(32)) bnz ();

  imm_gen_pipe #(.XLEN(32), .TAG_W(32), .EN_ZIMM(1'b1)) u32 (.clk(clk), .rst_n(rst_n), .flush(flush), .bus(b32));
  imm_gen_pipe #(.XLEN(64), .TAG_W(32), .EN_ZIMM(1'b1)) u64 (.clk(clk), .rst_n(rst_n), .flush(flush), .bus(b64));
  imm_gen_pipe #(.XLEN(32), .TAG_W(32), .EN_ZIMM(1'b0)) unz (.clk(clk), .rst_n(rst_n), .flush(flush), .bus(bnz));

  typedef struct {
    int          sel;
    logic [31:0] instr;
    logic [63:0] imm;
    logic [2:0]  typ;
    logic        ill;
  } vec_t;

  typedef struct {
    logic [63:0] imm;
    logic [2:0]  typ;
    logic        ill;
    logic [31:0] tag;
  } exp_t;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, want %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic idle_all();
    b32.in_valid = 1'b0; b64.in_valid = 1'b0; bnz.in_valid = 1'b0;
  endtask

  task automatic drive32(input logic [31:0] instr, input logic [31:0] tag);
    b32.in_valid = 1'b1; b32.in_instr = instr; b32.in_tag = tag;
  endtask

  // Spec-level reference: field extraction with plain signed arithmetic
  function automatic exp_t ref_dec(input logic [31:0] i, input bit x64, input bit ez);
    longint v;
    exp_t   e;
    v = 0; e.typ = 3'd0; e.ill = 1'b0; e.tag = '0;
    if (i[1:0] != 2'b11) e.ill = 1'b1;
    else case (i[6:0])
      7'b0000011, 7'b0010011, 7'b1100111, 7'b0001111: begin v = $signed(i[31:20]); e.typ = 3'd1; end
      7'b1110011:
        if (ez && i[14]) begin v = longint'(i[19:15]); e.typ = 3'd6; end
        else begin v = $signed(i[31:20]); e.typ = 3'd1; end
      7'b0100011: begin v = $signed({i[31:25], i[11:7]}); e.typ = 3'd2; end
      7'b1100011: begin v = $signed({i[31], i[7], i[30:25], i[11:8], 1'b0}); e.typ = 3'd3; end
      7'b0110111, 7'b0010111: begin v = $signed({i[31:12], 12'h000}); e.typ = 3'd4; end
      7'b1101111: begin v = $signed({i[31], i[19:12], i[20], i[30:21], 1'b0}); e.typ = 3'd5; end
      default: e.ill = 1'b1;
    endcase
    e.imm = x64 ? 64'(v) : {32'h0, v[31:0]};
    return e;
  endfunction

  function automatic logic [31:0] rnd_instr();
    logic [31:0] w;
    logic [6:0]  ops [10];
    ops = '{7'b0000011, 7'b0010011, 7'b1100111, 7'b0001111, 7'b1110011,
            7'b0100011, 7'b1100011, 7'b0110111, 7'b0010111, 7'b1101111};
    w = $urandom;
    if ($urandom_range(0, 4) != 0) w[6:0] = ops[$urandom_range(0, 9)];
    return w;
  endfunction

  vec_t        vecs [12];
  exp_t        q [$];
  exp_t        e;
  logic        a_v;
  logic [63:0] a_imm;
  logic [2:0]  a_t;
  logic        a_ill;
  logic [31:0] a_tag;
  logic [2:0]  t32;
  bit          fire_in;
  bit          fire_out;
  bit          do_flush;

  initial begin
    vecs[0]  = '{0, 32'h6cdff6e7, 64'h0000_06cd, 3'd1, 1'b0};
    vecs[1]  = '{0, 32'ha2dff623, 64'hffff_fa2c, 3'd2, 1'b0};
    vecs[2]  = '{0, 32'hf1eed7e3, 64'hffff_ff0e, 3'd3, 1'b0};
    vecs[3]  = '{0, 32'h888888ef, 64'hfff8_8088, 3'd5, 1'b0};
    vecs[4]  = '{0, 32'h300fd0f3, 64'h0000_001f, 3'd6, 1'b0};
    vecs[5]  = '{0, 32'h00000000, 64'h0,         3'd0, 1'b1};
    vecs[6]  = '{1, 32'habcdef97, 64'hffffffff_abcde000, 3'd4, 1'b0};
    vecs[7]  = '{1, 32'h12345637, 64'h00000000_12345000, 3'd4, 1'b0};
    vecs[8]  = '{1, 32'h888888ef, 64'hffffffff_fff88088, 3'd5, 1'b0};
    vecs[9]  = '{2, 32'h300fd0f3, 64'h0000_0300, 3'd1, 1'b0};
    vecs[10] = '{0, 32'h00000013, 64'h0,         3'd1, 1'b0};
    vecs[11] = '{0, 32'h6cdff6e4, 64'h0,         3'd0, 1'b1};

    idle_all();
    b32.in_instr = '0; b32.in_tag = '0; b32.out_ready = 1'b1;
    b64.in_instr = '0; b64.in_tag = '0; b64.out_ready = 1'b1;
    bnz.in_instr = '0; bnz.in_tag = '0; bnz.out_ready = 1'b1;

    // Reset state
    @(negedge clk);
    tick();
    check("rst_out_valid", b32.out_valid, 0);
    check("rst_out_imm", b32.out_imm, 0);
    t32 = b32.out_type;
    check("rst_out_type", t32, 0);
    check("rst_out_illegal", b32.out_illegal, 0);
    check("rst_out_tag", b32.out_tag, 0);
    rst_n = 1'b1;
    tick();
    check("rst_in_ready", b32.in_ready, 1);
    check("rst_out_valid_idle", b32.out_valid, 0);

    // Vector table, streamed back-to-back; each result one cycle after accept
    for (int k = 0; k <= 12; k++) begin
      if (k > 0) begin
        case (vecs[k-1].sel)
          0: begin a_v = b32.out_valid; a_imm = {32'h0, b32.out_imm}; a_t = b32.out_type;
                   a_ill = b32.out_illegal; a_tag = b32.out_tag; end
          1: begin a_v = b64.out_valid; a_imm = b64.out_imm; a_t = b64.out_type;
                   a_ill = b64.out_illegal; a_tag = b64.out_tag; end
          default: begin a_v = bnz.out_valid; a_imm = {32'h0, bnz.out_imm}; a_t = bnz.out_type;
                   a_ill = bnz.out_illegal; a_tag = bnz.out_tag; end
        endcase
        check($sformatf("vec%0d_valid", k-1), a_v, 1);
        check($sformatf("vec%0d_imm", k-1), a_imm, vecs[k-1].imm);
        check($sformatf("vec%0d_type", k-1), a_t, vecs[k-1].typ);
        check($sformatf("vec%0d_illegal", k-1), a_ill, vecs[k-1].ill);
        check($sformatf("vec%0d_tag", k-1), a_tag, k-1);
      end
      idle_all();
      if (k < 12) begin
        case (vecs[k].sel)
          0: begin b32.in_valid = 1'b1; b32.in_instr = vecs[k].instr; b32.in_tag = k; end
          1: begin b64.in_valid = 1'b1; b64.in_instr = vecs[k].instr; b64.in_tag = k; end
          default: begin bnz.in_valid = 1'b1; bnz.in_instr = vecs[k].instr; bnz.in_tag = k; end
        endcase
      end
      tick();
    end
    check("vec_drained", b32.out_valid, 0);

    // Backpressure: A held, B in skid, C refused until the skid drains
    b32.out_ready = 1'b0;
    drive32(vecs[0].instr, 100);
    tick();
    check("bp_a_valid", b32.out_valid, 1);
    check("bp_a_tag", b32.out_tag, 100);
    check("bp_ready_after_a", b32.in_ready, 1);
    drive32(vecs[1].instr, 101);
    tick();
    check("bp_ready_after_b", b32.in_ready, 0);
    check("bp_a_held_tag", b32.out_tag, 100);
    drive32(vecs[2].instr, 102);
    tick();
    check("bp_c_refused", b32.in_ready, 0);
    check("bp_a_held_imm", b32.out_imm, 64'h6cd);
    check("bp_a_held_tag2", b32.out_tag, 100);
    b32.out_ready = 1'b1;
    tick();
    check("bp_b_tag", b32.out_tag, 101);
    check("bp_b_imm", b32.out_imm, 64'hfffffa2c);
    check("bp_ready_reopen", b32.in_ready, 1);
    tick();
    check("bp_c_tag", b32.out_tag, 102);
    check("bp_c_valid", b32.out_valid, 1);
    idle_all();
    tick();
    check("bp_empty", b32.out_valid, 0);

    // Flush with output and skid full, plus an input in the flush cycle
    b32.out_ready = 1'b0;
    drive32(vecs[0].instr, 110);
    tick();
    drive32(vecs[1].instr, 111);
    tick();
    flush = 1'b1;
    drive32(vecs[2].instr, 112);
    tick();
    flush = 1'b0;
    idle_all();
    check("fl_out_valid", b32.out_valid, 0);
    check("fl_in_ready", b32.in_ready, 1);
    b32.out_ready = 1'b1;
    for (int c = 0; c < 4; c++) begin
      tick();
      check("fl_nothing_emerges", b32.out_valid, 0);
    end

    // Reset mid-stream with the skid full
    b32.out_ready = 1'b0;
    drive32(vecs[0].instr, 120);
    tick();
    drive32(vecs[1].instr, 121);
    tick();
    check("mr_skid_full", b32.in_ready, 0);
    rst_n = 1'b0;
    idle_all();
    tick();
    rst_n = 1'b1;
    check("mr_out_valid", b32.out_valid, 0);
    check("mr_out_imm", b32.out_imm, 0);
    t32 = b32.out_type;
    check("mr_out_type", t32, 0);
    check("mr_out_illegal", b32.out_illegal, 0);
    check("mr_out_tag", b32.out_tag, 0);
    check("mr_in_ready", b32.in_ready, 1);
    drive32(vecs[1].instr, 122);
    tick();
    check("mr_first_valid", b32.out_valid, 1);
    check("mr_first_tag", b32.out_tag, 122);
    check("mr_first_imm", b32.out_imm, 64'hfffffa2c);
    idle_all();
    b32.out_ready = 1'b1;
    tick();
    check("mr_no_stale", b32.out_valid, 0);

    // Random stream against a depth-2 FIFO model
    q.delete();
    for (int c = 0; c < 2000; c++) begin
      check("rnd_out_valid", b32.out_valid, q.size() > 0);
      check("rnd_in_ready", b32.in_ready, q.size() < 2);
      if (q.size() > 0) begin
        t32 = b32.out_type;
        check("rnd_imm", {32'h0, b32.out_imm}, q[0].imm);
        check("rnd_type", t32, q[0].typ);
        check("rnd_illegal", b32.out_illegal, q[0].ill);
        check("rnd_tag", b32.out_tag, q[0].tag);
      end
      do_flush        = ($urandom_range(0, 63) == 0);
      flush           = do_flush;
      b32.in_valid    = ($urandom_range(0, 3) != 0);
      b32.in_instr    = rnd_instr();
      b32.in_tag      = $urandom;
      b32.out_ready   = ($urandom_range(0, 3) != 0);
      fire_in  = b32.in_valid && (q.size() < 2);
      fire_out = (q.size() > 0) && b32.out_ready;
      e        = ref_dec(b32.in_instr, 1'b0, 1'b1);
      e.tag    = b32.in_tag;
      @(posedge clk);
      if (do_flush) q.delete();
      else begin
        if (fire_out) void'(q.pop_front());
        if (fire_in) q.push_back(e);
      end
      @(negedge clk);
    end
    flush = 1'b0;
    idle_all();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
